biquad_cascade_sched: RTL and testbench
=======================================

# biquad_cascade_sched

Time-multiplexed scheduler that runs a cascade of NUM_STAGES Q2.14 biquad sections through one shared 16×16 multiplier and one accumulator. It sits between the I2S receive path and the I2S transmit path, in place of per-band parallel filters. It owns per-stage history registers and double-buffered coefficient banks written from the SPI register decoder. Coefficient updates take effect atomically at sample boundaries.

## Interface
- NUM_STAGES, 4, number of cascaded biquad sections (1..8)
- DATA_W, 16, sample width, signed
- COEF_W, 16, coefficient width, signed Q2.14
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; sample_in is valid
- sample_in  in  DATA_W  x[n] into stage 0
- ready  out  1  high when idle; a sample_valid strobe is accepted only while ready=1
- out_valid  out  1  one-cycle pulse; sample_out holds a new y[n]
- sample_out  out  DATA_W  output of the last stage; held between pulses
- coef_we  in  1  write coef_data into the shadow bank
- coef_stage  in  3  target stage index; writes with index ≥ NUM_STAGES are ignored
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5..7 are ignored
- coef_data  in  COEF_W  coefficient value
- coef_commit  in  1  request a shadow→active copy of the whole bank
- overrun  out  1  sticky; set when sample_valid arrives while ready=0

The clock is named clk and the reset is named reset. Reset is synchronous and active-high; this is already decided.

## Operation
- FSM states: IDLE, MAC, WB.
- IDLE
  - ready=1.
  - On sample_valid: capture sample_in as the stage-0 input, set stage=0 and idx=0, clear the accumulator, and go to MAC.
- MAC: five cycles per stage, idx 0..4, one product per cycle.
  - Product order: b0·x, b1·x1, b2·x2, a1·y1, a2·y2.
  - The three b products are added to the accumulator; the two a products are subtracted.
- WB: one cycle.
  - res = scale(acc).
  - Update the stage history: x2←x1, x1←x, y2←y1, y1←res.
  - res becomes the input x of stage+1.
  - If stage = NUM_STAGES−1: sample_out←res, out_valid←1 (registered), go to IDLE.
  - Otherwise: stage++, idx=0, clear the accumulator, go to MAC.
- Arithmetic
  - Each product is 32-bit signed.
  - The accumulator is 35-bit signed, which holds the sum of five products with no overflow.
  - scale(acc) = acc[29:14]. See Configuration for saturation.
- Coefficient banks
  - coef_we writes the shadow bank only. The active bank is read only by MAC.
  - coef_commit sets a pending flag.
  - When the FSM is in IDLE with pending=1, the active bank is set to the shadow bank and pending is cleared, both in that same cycle.
  - If sample_valid arrives in that same cycle, the new sample uses the new coefficients.
  - A commit that arrives during MAC or WB is deferred. The sample in flight finishes entirely with the old bank.
  - coef_we and coef_commit in the same cycle: the write is included in the commit.
- A sample_valid that arrives while ready=0 is dropped and sets overrun. Stage state is not altered.
- Reset values
  - Active and shadow banks: b0=0x4000 (unity), all other coefficients 0, for every stage.
  - All history registers 0.
  - FSM in IDLE, ready=1, out_valid=0, sample_out=0, overrun=0, pending=0.
- Reset asserted mid-operation aborts the sample in flight: no out_valid is produced and all of the above reset values apply.

## Timing
- If sample_valid is accepted at cycle T:
  - Stage s runs MAC during T+1+6s .. T+5+6s and WB at T+6+6s.
  - out_valid is high at T+6·NUM_STAGES+1 (T+25 with the default parameters).
  - ready is high again at T+6·NUM_STAGES+1.
- Maximum sample rate is clk/(6·NUM_STAGES+1).
- out_valid is a single-cycle pulse. sample_out is stable until the next pulse.

## Configuration
- BIQUAD_SAT_EN defined: scale() saturates.
  - If acc[34:29] is not all equal to acc[34] (sign extension), the result is clamped to 0x7FFF or 0x8000 according to acc[34].
  - The clamped value is also the value stored in y1.
- BIQUAD_SAT_EN undefined: scale() truncates (wraps) with no clamping.

## Structure
- Package biquad_pkg holds:
  - DATA_W, COEF_W, ACC_W=35
  - coefficient index enum (B0, B1, B2, A1, A2)
  - FSM state enum
  - COEF_UNITY=16'sh4000
- Sub-module biquad_mac holds:
  - the registered multiplier and 35-bit accumulator
  - inputs: clr, add/sub select
  - scale() with the BIQUAD_SAT_EN logic
- The scheduler holds the FSM, the coefficient banks and the history arrays.

## Test plan
- Passthrough: after reset, sample_in=1000 → out_valid at T+25 with sample_out=1000; ready=0 during T+1..T+24.
- Gain: write stage0 b0=0x2000 and commit; input 1000 → 500. Input −1000 → −500.
- IIR feedback: stage0 b0=0x4000, a1=0xE000 (−0.5); impulse 8192 then zeros → outputs 8192, 4096, 2048, 1024.
- Saturation: stage0 b0=0x7FFF, input 0x7FFF → sample_out 0x7FFF with BIQUAD_SAT_EN, 0xFFFC (−4) without.
- Deferred commit: commit b0=0x2000 at T+10 with input 1000 → current output 1000; next sample 1000 → 500.
- Overrun and reset: sample_valid at T+3 → dropped, overrun=1, output unchanged. Reset at T+12 → no out_valid, all outputs at reset values, overrun=0.

Source files
------------

// File: rtl/biquad_cascade_sched_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade:
// data/coefficient widths, accumulator width, FSM state and coefficient index enums.
package biquad_pkg;

   localparam int DATA_W     = 16;
   localparam int COEF_W     = 16;
   localparam int PROD_W     = 32;
   localparam int ACC_W      = 35;
   localparam int MAX_STAGES = 8;

   localparam logic signed [COEF_W-1:0] COEF_UNITY = 16'sh4000;

   typedef enum logic [2:0] {
      B0 = 3'd0,
      B1 = 3'd1,
      B2 = 3'd2,
      A1 = 3'd3,
      A2 = 3'd4
   } coef_idx_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      WB   = 2'd2
   } state_e;

   typedef struct packed {
      logic signed [COEF_W-1:0] b0;
      logic signed [COEF_W-1:0] b1;
      logic signed [COEF_W-1:0] b2;
      logic signed [COEF_W-1:0] a1;
      logic signed [COEF_W-1:0] a2;
   } coef_set_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] x1;
      logic signed [DATA_W-1:0] x2;
      logic signed [DATA_W-1:0] y1;
      logic signed [DATA_W-1:0] y2;
   } hist_t;

   localparam coef_set_t COEF_RESET = '{b0: COEF_UNITY, b1: '0, b2: '0, a1: '0, a2: '0};

endpackage

// File: rtl/biquad_cascade_sched_if.sv
// Sample stream, coefficient write port and status flags of the biquad cascade.
interface biquad_cascade_sched_if;
   import biquad_pkg::*;

   logic                     sample_valid;
   logic signed [DATA_W-1:0] sample_in;
   logic                     ready;
   logic                     out_valid;
   logic signed [DATA_W-1:0] sample_out;
   logic                     coef_we;
   logic [2:0]               coef_stage;
   logic [2:0]               coef_sel;
   logic signed [COEF_W-1:0] coef_data;
   logic                     coef_commit;
   logic                     overrun;

   modport master (
      output sample_valid, sample_in, coef_we, coef_stage, coef_sel, coef_data, coef_commit,
      input  ready, out_valid, sample_out, overrun
   );

   modport slave (
      input  sample_valid, sample_in, coef_we, coef_stage, coef_sel, coef_data, coef_commit,
      output ready, out_valid, sample_out, overrun
   );

endinterface

// File: rtl/biquad_cascade_sched_mac.sv
// Shared multiplier feeding a registered 35-bit accumulator, plus the Q2.14 rescale.
// BIQUAD_SAT_EN: when defined, the rescale clamps to 0x7FFF/0x8000 instead of wrapping.
module biquad_mac
   import biquad_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     sub,
   input  logic signed [COEF_W-1:0] coef,
   input  logic signed [DATA_W-1:0] data,
   output logic signed [DATA_W-1:0] res
);

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc;

   assign prod     = coef * data;
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
      end
   end

`ifdef BIQUAD_SAT_EN
   // Bits 34:29 must all match the sign for acc[29:14] to represent the value.
   always_comb begin
      res = acc[29:14];
      if (acc[34:29] != {6{acc[34]}}) begin
         res = acc[34] ? 16'sh8000 : 16'sh7FFF;
      end
   end
`else
   assign res = acc[29:14];
`endif

endmodule

// File: rtl/biquad_cascade_sched.sv
// Runs NUM_STAGES biquad sections through one shared MAC, six cycles per stage,
// with double-buffered coefficient banks that switch only while idle.
//
// state | meaning
// IDLE  | ready; waits for sample_valid, applies a pending coefficient commit
// MAC   | five products for the current stage, idx 0..4 (b0 b1 b2 a1 a2)
// WB    | rescale, update stage history, advance stage or emit output
module biquad_cascade_sched
   import biquad_pkg::*;
#(
   parameter int NUM_STAGES = 4
) (
   input logic                   clk,
   input logic                   reset,
   biquad_cascade_sched_if.slave bus
);

   localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

   state_e state, state_nxt;
   logic [2:0] stage, stage_nxt;
   logic [2:0] idx, idx_nxt;
   logic       accept, wb, mac_clr, mac_en, mac_sub, bank_copy;

   logic signed [DATA_W-1:0] x_cur;
   logic signed [DATA_W-1:0] mac_data;
   logic signed [DATA_W-1:0] mac_res;
   logic signed [COEF_W-1:0] mac_coef;
   logic signed [DATA_W-1:0] sample_out;
   logic                     out_valid;
   logic                     overrun;
   logic                     pending;

   coef_set_t shadow [MAX_STAGES];
   coef_set_t active [MAX_STAGES];
   hist_t     hist   [MAX_STAGES];
   coef_set_t cs;
   hist_t     h;

   assign bus.ready      = (state == IDLE);
   assign bus.out_valid  = out_valid;
   assign bus.sample_out = sample_out;
   assign bus.overrun    = overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         stage <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         stage <= stage_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stage_nxt = stage;
      idx_nxt   = idx;
      accept    = 1'b0;
      wb        = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.sample_valid) begin
               accept    = 1'b1;
               stage_nxt = '0;
               idx_nxt   = '0;
               mac_clr   = 1'b1;
               state_nxt = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (idx == 3'd4) begin
               state_nxt = WB;
            end else begin
               idx_nxt = idx + 3'd1;
            end
         end
         WB: begin
            wb = 1'b1;
            if (stage == LAST_STAGE) begin
               state_nxt = IDLE;
            end else begin
               stage_nxt = stage + 3'd1;
               idx_nxt   = '0;
               mac_clr   = 1'b1;
               state_nxt = MAC;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cs       = active[stage];
      h        = hist[stage];
      mac_coef = cs.b0;
      mac_data = x_cur;
      mac_sub  = 1'b0;
      case (coef_idx_e'(idx))
         B1: begin mac_coef = cs.b1; mac_data = h.x1; end
         B2: begin mac_coef = cs.b2; mac_data = h.x2; end
         A1: begin mac_coef = cs.a1; mac_data = h.y1; mac_sub = 1'b1; end
         A2: begin mac_coef = cs.a2; mac_data = h.y2; mac_sub = 1'b1; end
         default: ;
      endcase
   end

   biquad_mac u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .sub   (mac_sub),
      .coef  (mac_coef),
      .data  (mac_data),
      .res   (mac_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cur      <= '0;
         sample_out <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < MAX_STAGES; i++) hist[i] <= '0;
      end else begin
         out_valid <= 1'b0;
         if (bus.sample_valid && (state != IDLE)) overrun <= 1'b1;
         if (accept) x_cur <= bus.sample_in;
         if (wb) begin
            hist[stage] <= '{x1: x_cur, x2: h.x1, y1: mac_res, y2: h.y1};
            x_cur       <= mac_res;
            if (stage == LAST_STAGE) begin
               sample_out <= mac_res;
               out_valid  <= 1'b1;
            end
         end
      end
   end

   // A commit is only honoured in IDLE so a sample never mixes two banks.
   assign bank_copy = (state == IDLE) && pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= 1'b0;
         for (int i = 0; i < MAX_STAGES; i++) begin
            shadow[i] <= COEF_RESET;
            active[i] <= COEF_RESET;
         end
      end else begin
         pending <= bus.coef_commit | (pending & ~bank_copy);
         if (bank_copy) begin
            for (int i = 0; i < MAX_STAGES; i++) active[i] <= shadow[i];
         end
         if (bus.coef_we && (int'(bus.coef_stage) < NUM_STAGES)) begin
            case (coef_idx_e'(bus.coef_sel))
               B0: shadow[bus.coef_stage].b0 <= bus.coef_data;
               B1: shadow[bus.coef_stage].b1 <= bus.coef_data;
               B2: shadow[bus.coef_stage].b2 <= bus.coef_data;
               A1: shadow[bus.coef_stage].a1 <= bus.coef_data;
               A2: shadow[bus.coef_stage].a2 <= bus.coef_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Directed vectors for the biquad cascade; expected outputs go into a queue that a
// negedge monitor pops and compares (value and arrival cycle) on every out_valid.
module tb_biquad_cascade_sched;
   import biquad_pkg::*;

   localparam int NS  = 4;
   localparam int LAT = 6 * NS + 1;

   typedef struct {
      logic signed [15:0] val;
      int                 cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   biquad_cascade_sched_if bus_if();

   biquad_cascade_sched #(.NUM_STAGES(NS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus_if.out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid cyc=%0d got=%0d required=no pulse", cyc, bus_if.sample_out);
         end else begin
            e = q.pop_front();
            if (bus_if.sample_out !== e.val || cyc != e.cyc) begin
               errors++;
               $display("FAIL sample_out got=%0d at cyc %0d required=%0d at cyc %0d",
                        bus_if.sample_out, cyc, e.val, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(1);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
   endtask

   task automatic wr(input bit we, input int st, input int sel, input logic [15:0] d, input bit cm);
      tick(1);
      bus_if.coef_we     = we;
      bus_if.coef_stage  = 3'(st);
      bus_if.coef_sel    = 3'(sel);
      bus_if.coef_data   = d;
      bus_if.coef_commit = cm;
      tick(1);
      bus_if.coef_we     = 1'b0;
      bus_if.coef_commit = 1'b0;
   endtask

   // Drives one strobe in cycle T; returns just after the edge that starts T+1.
   task automatic issue(input logic signed [15:0] x, input logic signed [15:0] e, input bit push);
      exp_t item;
      tick(1);
      bus_if.sample_valid = 1'b1;
      bus_if.sample_in    = x;
      if (push) begin
         item.val = e;
         item.cyc = cyc + LAT;
         q.push_back(item);
      end
      tick(1);
      bus_if.sample_valid = 1'b0;
   endtask

   task automatic run_sample(input logic signed [15:0] x, input logic signed [15:0] e);
      int busy_bad;
      busy_bad = 0;
      issue(x, e, 1'b1);
      for (int k = 1; k < LAT; k++) begin
         @(negedge clk);
         if (bus_if.ready !== 1'b0) busy_bad++;
      end
      chk("ready_low_while_busy", busy_bad, 0);
      @(negedge clk);
      chk("ready_back_high", int'(bus_if.ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d required=finish", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.sample_valid = 1'b0;
      bus_if.sample_in    = '0;
      bus_if.coef_we      = 1'b0;
      bus_if.coef_stage   = '0;
      bus_if.coef_sel     = '0;
      bus_if.coef_data    = '0;
      bus_if.coef_commit  = 1'b0;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(bus_if.ready), 1);
      chk("rst_out_valid", int'(bus_if.out_valid), 0);
      chk("rst_sample_out", int'(bus_if.sample_out), 0);
      chk("rst_overrun", int'(bus_if.overrun), 0);

      // Writes to a nonexistent stage or an invalid selector must not land anywhere.
      wr(1'b1, 4, 0, 16'h0000, 1'b0);
      wr(1'b1, 0, 5, 16'h0000, 1'b0);
      wr(1'b1, 0, 7, 16'h1234, 1'b1);
      run_sample(16'sd1000, 16'sd1000);
      run_sample(-16'sd1234, -16'sd1234);

      // Gain: write and commit in the same cycle.
      wr(1'b1, 0, 0, 16'h2000, 1'b1);
      run_sample(16'sd1000, 16'sd500);
      run_sample(-16'sd1000, -16'sd500);
      wr(1'b1, 2, 0, 16'h8000, 1'b1);
      run_sample(16'sd1000, -16'sd1000);

      // Deferred commit at T+10 while a sample is in flight.
      do_reset();
      issue(16'sd1000, 16'sd1000, 1'b1);
      tick(9);
      bus_if.coef_we     = 1'b1;
      bus_if.coef_stage  = 3'd0;
      bus_if.coef_sel    = 3'd0;
      bus_if.coef_data   = 16'sh2000;
      bus_if.coef_commit = 1'b1;
      tick(1);
      bus_if.coef_we     = 1'b0;
      bus_if.coef_commit = 1'b0;
      tick(15);
      chk("deferred_queue_drained", q.size(), 0);
      run_sample(16'sd1000, 16'sd500);

      // Overrun: a strobe at T+3 is dropped.
      issue(16'sd1000, 16'sd500, 1'b1);
      tick(2);
      bus_if.sample_valid = 1'b1;
      bus_if.sample_in    = 16'sd5000;
      tick(1);
      bus_if.sample_valid = 1'b0;
      tick(22);
      chk("overrun_set", int'(bus_if.overrun), 1);
      chk("overrun_output_held", int'(bus_if.sample_out), 500);
      chk("overrun_queue_drained", q.size(), 0);

      // Reset at T+12 aborts the sample; no pulse may follow.
      issue(16'sd2000, 16'sd0, 1'b0);
      tick(11);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_ready", int'(bus_if.ready), 1);
      chk("midrst_overrun", int'(bus_if.overrun), 0);
      chk("midrst_sample_out", int'(bus_if.sample_out), 0);
      chk("midrst_out_valid", int'(bus_if.out_valid), 0);
      tick(30);
      run_sample(16'sd1000, 16'sd1000);

      // IIR feedback with a1 = -0.5.
      do_reset();
      wr(1'b1, 0, 3, 16'hE000, 1'b0);
      wr(1'b0, 0, 0, 16'h0000, 1'b1);
      run_sample(16'sd8192, 16'sd8192);
      run_sample(16'sd0, 16'sd4096);
      run_sample(16'sd0, 16'sd2048);
      run_sample(16'sd0, 16'sd1024);

      // Saturation of the first stage's rescale.
      do_reset();
      wr(1'b1, 0, 0, 16'h7FFF, 1'b1);
`ifdef BIQUAD_SAT_EN
      run_sample(16'sh7FFF, 16'sh7FFF);
`else
      run_sample(16'sh7FFF, -16'sd4);
`endif

      tick(5);
      chk("queue_empty_at_end", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
